// File: rtl/irq_if.sv
// irq_if: CLINT/external interrupt inputs, CSR access port and trap handshake between the core and irq_ctrl.
interface irq_if;
  logic        software_int;
  logic        timer_int;
  logic        ext_int;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        irq_ready;
  logic        trap_req;
  logic [31:0] trap_cause;
  logic        trap_ack;
  logic        mret;
  logic        wfi_wake;
  modport slave (
    input  software_int, timer_int, ext_int, csr_addr, csr_we, csr_wdata, irq_ready, trap_ack, mret,
    output csr_rdata, trap_req, trap_cause, wfi_wake
  );
  modport master (
    output software_int, timer_int, ext_int, csr_addr, csr_we, csr_wdata, irq_ready, trap_ack, mret,
    input  csr_rdata, trap_req, trap_cause, wfi_wake
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: machine-mode interrupt controller holding mstatus/mie/mip/mcause and arbitrating trap requests.
module irq_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  irq_if.slave bus
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  // Three-bit source vectors are ordered {MEI, MTI, MSI}
  logic [2:0] r_mie, r_sel, w_mip, w_pend, w_sel, w_wmask;
  logic       r_mstatus_mie, r_mpie, r_mcause_int;
  logic [3:0] r_mcause_code, w_code;
  logic       w_wr_ms, w_wr_mie, w_wr_mc, w_ack, w_mret, w_eligible, w_withdraw;
  assign w_mip      = {r_sync[SYNC_STAGES-1], bus.timer_int, bus.software_int};
  assign w_pend     = w_mip & r_mie;
  assign w_eligible = r_mstatus_mie && |w_pend;
  assign w_sel      = w_pend[2] ? 3'b100 : w_pend[0] ? 3'b001 : w_pend[1] ? 3'b010 : 3'b000;
  assign w_code     = r_sel[2] ? 4'd11 : r_sel[0] ? 4'd3 : r_sel[1] ? 4'd7 : 4'd0;
  assign w_wmask    = {bus.csr_wdata[11], bus.csr_wdata[7], bus.csr_wdata[3]};
  assign w_wr_ms    = bus.csr_we && bus.csr_addr == 12'h300;
  assign w_wr_mie   = bus.csr_we && bus.csr_addr == 12'h304;
  assign w_wr_mc    = bus.csr_we && bus.csr_addr == 12'h342;
  assign w_ack      = r_state == REQ && bus.trap_ack;
  assign w_mret     = r_state == IDLE && bus.mret;
  // A pending request is withdrawn when software disables the source it was raised for
  assign w_withdraw = (w_wr_ms && !bus.csr_wdata[3]) || (w_wr_mie && (w_wmask & r_sel) == 3'b000);
  assign bus.trap_req   = r_state == REQ;
  assign bus.trap_cause = {|r_sel, 27'b0, w_code};
  assign bus.wfi_wake   = |w_pend;
  assign bus.csr_rdata  =
    bus.csr_addr == 12'h300 ? {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mstatus_mie, 3'b0} :
    bus.csr_addr == 12'h304 ? {20'b0, r_mie[2], 3'b0, r_mie[1], 3'b0, r_mie[0], 3'b0} :
    bus.csr_addr == 12'h344 ? {20'b0, w_mip[2], 3'b0, w_mip[1], 3'b0, w_mip[0], 3'b0} :
    bus.csr_addr == 12'h342 ? {r_mcause_int, 27'b0, r_mcause_code} : 32'b0;
  always_comb begin
    w_state_nxt = r_state == IDLE ? ((w_eligible && bus.irq_ready) ? REQ : IDLE)
                                  : ((bus.trap_ack || w_withdraw) ? IDLE : REQ);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_sync        <= '0;
      r_sel         <= 3'b000;
      r_mie         <= 3'b000;
      r_mstatus_mie <= 1'b0;
      r_mpie        <= 1'b0;
      r_mcause_int  <= 1'b0;
      r_mcause_code <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.ext_int};
      if (r_state == IDLE && w_state_nxt == REQ) r_sel <= w_sel;
      if (w_wr_mie) r_mie <= w_wmask;
      if (w_ack) begin
        r_mpie        <= r_mstatus_mie;
        r_mstatus_mie <= 1'b0;
      end else if (w_wr_ms) begin
        r_mpie        <= bus.csr_wdata[7];
        r_mstatus_mie <= bus.csr_wdata[3];
      end else if (w_mret) begin
        r_mstatus_mie <= r_mpie;
        r_mpie        <= 1'b1;
      end
      if (w_ack) {r_mcause_int, r_mcause_code} <= {|r_sel, w_code};
      else if (w_wr_mc) {r_mcause_int, r_mcause_code} <= {bus.csr_wdata[31], bus.csr_wdata[3:0]};
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed CSR vector table plus hand-written trap handshake sequences for irq_ctrl.
module tb_irq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  irq_if bus();
  irq_ctrl #(.SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    logic [11:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr = a;
    bus.csr_we = 1'b1;
    bus.csr_wdata = d;
    tick();
    bus.csr_we = 1'b0;
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a;
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask
  initial begin
    bus.software_int = 0; bus.timer_int = 0; bus.ext_int = 0;
    bus.csr_addr = '0; bus.csr_we = 0; bus.csr_wdata = '0;
    bus.irq_ready = 0; bus.trap_ack = 0; bus.mret = 0;
    vecs = '{
      '{"rst_mstatus", 12'h300, 1'b0, 32'h0,        32'h0000_1800},
      '{"rst_mie",     12'h304, 1'b0, 32'h0,        32'h0},
      '{"rst_mcause",  12'h342, 1'b0, 32'h0,        32'h0},
      '{"rst_mip",     12'h344, 1'b0, 32'h0,        32'h0},
      '{"unlisted_rd", 12'h123, 1'b0, 32'h0,        32'h0},
      '{"mie_all",     12'h304, 1'b1, 32'hFFFF_FFFF, 32'h0000_0888},
      '{"mcause_all",  12'h342, 1'b1, 32'hFFFF_FFFF, 32'h8000_000F},
      '{"mstatus_all", 12'h300, 1'b1, 32'hFFFF_FFFF, 32'h0000_1888},
      '{"mstatus_0",   12'h300, 1'b1, 32'h0,        32'h0000_1800},
      '{"mip_ro",      12'h344, 1'b1, 32'hFFFF_FFFF, 32'h0},
      '{"unlisted_wr", 12'h123, 1'b1, 32'hFFFF_FFFF, 32'h0},
      '{"mcause_0",    12'h342, 1'b1, 32'h0,        32'h0},
      '{"mie_mti",     12'h304, 1'b1, 32'h0000_0080, 32'h0000_0080}
    };
    #12;
    chk("rst_trap_req", {31'b0, bus.trap_req}, 32'h0);
    chk("rst_trap_cause", bus.trap_cause, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end
    // Timer trap: mie=0x80 from table, enable MIE, raise timer with core ready
    wr(12'h300, 32'h8);
    bus.timer_int = 1; bus.irq_ready = 1;
    #1;
    chk("mti_not_yet", {31'b0, bus.trap_req}, 32'h0);
    tick();
    chk("mti_req", {31'b0, bus.trap_req}, 32'h1);
    chk("mti_cause", bus.trap_cause, 32'h8000_0007);
    bus.trap_ack = 1;
    tick();
    bus.trap_ack = 0;
    chk("mti_ack_req", {31'b0, bus.trap_req}, 32'h0);
    rd("mti_mcause", 12'h342, 32'h8000_0007);
    rd("mti_mstatus", 12'h300, 32'h0000_1880);
    chk("wfi_wake_mie0", {31'b0, bus.wfi_wake}, 32'h1);
    tick();
    chk("no_req_mie0", {31'b0, bus.trap_req}, 32'h0);
    // All sources high: external wins once through the synchronizer
    bus.irq_ready = 0;
    bus.software_int = 1; bus.ext_int = 1;
    wr(12'h304, 32'h888);
    wr(12'h300, 32'h8);
    rd("mip_all", 12'h344, 32'h0000_0888);
    bus.irq_ready = 1;
    tick();
    chk("mei_req", {31'b0, bus.trap_req}, 32'h1);
    chk("mei_cause", bus.trap_cause, 32'h8000_000B);
    bus.trap_ack = 1;
    tick();
    bus.trap_ack = 0;
    rd("mei_mcause", 12'h342, 32'h8000_000B);
    // Cause held after source drops; mstatus write withdraws request
    bus.irq_ready = 0; bus.software_int = 0; bus.ext_int = 0;
    wr(12'h304, 32'h80);
    wr(12'h300, 32'h8);
    bus.irq_ready = 1;
    tick();
    chk("hold_req", {31'b0, bus.trap_req}, 32'h1);
    bus.timer_int = 0;
    tick();
    chk("hold_req2", {31'b0, bus.trap_req}, 32'h1);
    chk("hold_cause", bus.trap_cause, 32'h8000_0007);
    wr(12'h300, 32'h0);
    chk("withdraw_req", {31'b0, bus.trap_req}, 32'h0);
    rd("withdraw_mcause", 12'h342, 32'h8000_000B);
    // MRET restores MIE from MPIE
    wr(12'h300, 32'h80);
    rd("pre_mret", 12'h300, 32'h0000_1880);
    bus.mret = 1;
    tick();
    bus.mret = 0;
    rd("post_mret", 12'h300, 32'h0000_1888);
    // Ack collides with mstatus write and mret: ack wins
    bus.timer_int = 1;
    tick();
    chk("coll_req", {31'b0, bus.trap_req}, 32'h1);
    bus.trap_ack = 1; bus.mret = 1;
    wr(12'h300, 32'h8);
    bus.trap_ack = 0; bus.mret = 0;
    chk("coll_req_low", {31'b0, bus.trap_req}, 32'h0);
    rd("coll_mstatus", 12'h300, 32'h0000_1880);
    // Asynchronous reset mid-request
    bus.irq_ready = 0;
    wr(12'h300, 32'h8);
    bus.irq_ready = 1;
    tick();
    chk("pre_rst_req", {31'b0, bus.trap_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, bus.trap_req}, 32'h0);
    chk("async_rst_cause", bus.trap_cause, 32'h0);
    rd("async_rst_mstatus", 12'h300, 32'h0000_1800);
    rd("async_rst_mie", 12'h304, 32'h0);
    chk("async_rst_wfi", {31'b0, bus.wfi_wake}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_req", {31'b0, bus.trap_req}, 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
